quad_encoder_rx: RTL
====================

Name: quad_encoder_rx

Overview:
- Input-direction counterpart of the motor pin matrix. It reads quadrature feedback (A, B, index) that arrives on PIOIN26 connector pins from a motor-mounted encoder.
- Synchronizes and glitch-filters the three pins, then decodes the Gray sequence into a signed position count, direction and step strobes.
- Flags illegal transitions.
- Sits between the PIOIN26 input pins and the motor-control logic that drives the step/brush outputs.

Parameters:
- POS_W, 32, width of the position counter (two's complement, wraps).
- FILT_LEN, 4, consecutive sample ticks a new pin level must hold before it is accepted (≥1).
- SAMPLE_DIV, 1, clock cycles per filter sample tick (≥1; 1 = every cycle).

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enc_a  in  1  encoder channel A, asynchronous pin.
- enc_b  in  1  encoder channel B, asynchronous pin.
- enc_i  in  1  encoder index, asynchronous pin.
- index_en  in  1  when 1, a filtered index rising edge zeroes position.
- clear  in  1  synchronous clear of position, error and direction.
- position  out  POS_W  signed quadrature count (4 counts per encoder line).
- direction  out  1  direction of the last accepted step: 1 = forward, 0 = reverse.
- step_pulse  out  1  one-cycle strobe per accepted count.
- index_seen  out  1  one-cycle strobe on a filtered index rising edge (independent of index_en).
- error  out  1  sticky; set on an illegal A/B transition.
- ready  out  1  1 once the decoder is in RUN.

Behaviour:
- Reset (synchronous): position=0, direction=0, step_pulse=0, index_seen=0, error=0, ready=0. Synchronizer, filter and prescaler registers = 0. FSM = INIT. Reset asserted mid-operation aborts everything on that edge.
- Synchronizer: two flops per pin. Filter and decoder use only the second-stage outputs (a_s, b_s, i_s).
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. tick=1 in the cycle where count == SAMPLE_DIV-1. It runs in all FSM states.
- FSM:
  - INIT: waits 2 cycles for the synchronizer to fill, then goes to SNAP.
  - SNAP: one cycle. Loads the filtered levels and prev_ab directly from a_s/b_s/i_s, clears the filter counters, goes to RUN. This guarantees no spurious count or error from reset-time pin levels.
  - RUN: ready=1. Stays in RUN until reset.
- Filter (RUN only, per pin, on tick):
  - Sync level equals the filtered level: counter=0.
  - Sync level differs: counter increments.
  - When counter reaches FILT_LEN-1 and the level still differs: filtered level takes the new value and counter=0.
  - Any tick with a matching level restarts the qualification.
- Decoder (RUN, every cycle) compares prev_ab with the current filtered {A,B}, then prev_ab takes filtered {A,B}:
  - Forward (+1, direction=1): 00→10, 10→11, 11→01, 01→00.
  - Reverse (−1, direction=0): 00→01, 01→11, 11→10, 10→00.
  - No change: nothing.
  - Both bits changed: no count, error=1 (sticky), direction unchanged.
- Accepted count: position updated and step_pulse=1 for exactly that cycle.
- Position arithmetic: modulo 2^POS_W. 0x7FFFFFFF+1 → 0x80000000; 0−1 → all ones.
- Priority within one cycle, highest first: reset > clear > index zeroing > count.
  - clear: position=0, error=0, direction=0. A coincident step or index in that cycle is discarded and step_pulse=0.
  - Filtered index rising edge with index_en=1: position=0. A coincident step is discarded, but step_pulse still asserts and direction still updates.
  - index_seen asserts on every filtered index rising edge, regardless of index_en.
- Latency (SAMPLE_DIV=1): a pin change stable from before rising edge k is reflected in position and step_pulse after edge k+FILT_LEN+2. For general SAMPLE_DIV, the filter span is FILT_LEN ticks.
- Pulses shorter than FILT_LEN ticks never reach the decoder.

Test Plan:
- Reset, pins A=1 B=1, FILT_LEN=4 → ready=1 after 3 cycles; position=0, error=0, no step_pulse.
- Forward sequence 00→10→11→01→00 repeated 3 times, each level held 8 cycles → position=12, direction=1, 12 step_pulses, each on the (FILT_LEN+3)th edge after its pin change.
- Reverse sequence from position 0 for 1 state → position=0xFFFFFFFF, direction=0. Then 2 forward states → position=1.
- A held 3 cycles then released (FILT_LEN=4) → no step_pulse, position unchanged. Set A and B simultaneously 00→11 → error=1, position unchanged. Then assert clear → error=0, position=0.
- Position=7, index_en=1, index pulse 10 cycles → position=0, one index_seen strobe. Repeat with index_en=0 → index_seen strobes, position unchanged.
- Position=5, clear coincident with an accepted step → position=0, step_pulse=0. Reset asserted mid-sequence → all outputs 0, ready returns 1 after 3 cycles, no spurious count.

Source files
------------

// File: rtl/quad_encoder_rx_if.sv
// Encoder pin inputs and decoded position outputs of quad_encoder_rx.
// master: pin/control side driving enc_*, index_en, clear; slave: decoder.
interface quad_encoder_rx_if #(
  parameter int POS_W = 32
);
  logic             enc_a;
  logic             enc_b;
  logic             enc_i;
  logic             index_en;
  logic             clear;
  logic [POS_W-1:0] position;
  logic             direction;
  logic             step_pulse;
  logic             index_seen;
  logic             error;
  logic             ready;

  modport master (
    output enc_a, enc_b, enc_i, index_en, clear,
    input  position, direction, step_pulse,
    input  index_seen, error, ready
  );

  modport slave (
    input  enc_a, enc_b, enc_i, index_en, clear,
    output position, direction, step_pulse,
    output index_seen, error, ready
  );
endinterface

// File: rtl/quad_encoder_rx.sv
// Quadrature encoder receiver: sync, glitch filter, Gray decode to position.
// Ports: clock, reset (sync, high), bus (slave: pins in, position/strobes out).
module quad_encoder_rx #(
  parameter int POS_W      = 32,
  parameter int FILT_LEN   = 4,
  parameter int SAMPLE_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  quad_encoder_rx_if.slave bus
);
  localparam int CW = $clog2(FILT_LEN) + 1;
  localparam int PW = $clog2(SAMPLE_DIV) + 1;
  localparam logic [CW-1:0] CMAX = CW'(FILT_LEN - 1);
  localparam logic [PW-1:0] PMAX = PW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    INIT,
    SNAP,
    RUN
  } state_t;

  state_t        state;
  logic          init_cnt;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [PW-1:0] pcnt;
  logic [2:0]    flt;
  logic [CW-1:0] fcnt [3];
  logic [1:0]    prev_ab;
  logic          prev_i;

  logic          tick;
  logic [1:0]    cur_ab;
  logic          fwd;
  logic          rev;
  logic          bad;
  logic          idx_rise;
  logic          idx_zero;

  // pin bit order everywhere: [0]=A, [1]=B, [2]=index
  assign tick     = (pcnt == PMAX);
  assign cur_ab   = {flt[0], flt[1]};
  assign bad      = ((prev_ab ^ cur_ab) == 2'b11);
  assign idx_rise = flt[2] & ~prev_i;
  assign idx_zero = idx_rise & bus.index_en;

  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    unique case ({prev_ab, cur_ab})
      4'b0010, 4'b1011,
      4'b1101, 4'b0100: fwd = 1'b1;
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: rev = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= INIT;
      init_cnt       <= 1'b0;
      sync1          <= '0;
      sync2          <= '0;
      pcnt           <= '0;
      flt            <= '0;
      fcnt           <= '{default: '0};
      prev_ab        <= '0;
      prev_i         <= 1'b0;
      bus.position   <= '0;
      bus.direction  <= 1'b0;
      bus.step_pulse <= 1'b0;
      bus.index_seen <= 1'b0;
      bus.error      <= 1'b0;
      bus.ready      <= 1'b0;
    end else begin
      sync1          <= {bus.enc_i, bus.enc_b, bus.enc_a};
      sync2          <= sync1;
      pcnt           <= tick ? '0 : pcnt + 1'b1;
      bus.step_pulse <= 1'b0;
      bus.index_seen <= 1'b0;
      unique case (state)
        INIT: begin
          init_cnt <= 1'b1;
          if (init_cnt) state <= SNAP;
        end
        SNAP: begin
          // adopt current pin levels so reset-time state never counts
          flt       <= sync2;
          prev_ab   <= {sync2[0], sync2[1]};
          prev_i    <= sync2[2];
          fcnt      <= '{default: '0};
          bus.ready <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          prev_ab <= cur_ab;
          prev_i  <= flt[2];
          if (tick) begin
            for (int p = 0; p < 3; p++) begin
              if (sync2[p] == flt[p]) begin
                fcnt[p] <= '0;
              end else if (fcnt[p] == CMAX) begin
                flt[p]  <= sync2[p];
                fcnt[p] <= '0;
              end else begin
                fcnt[p] <= fcnt[p] + 1'b1;
              end
            end
          end
          if (!bus.clear) begin
            bus.index_seen <= idx_rise;
            if (fwd | rev) begin
              bus.step_pulse <= 1'b1;
              bus.direction  <= fwd;
            end
            // index zeroing overrides the count but not the strobe
            if (idx_zero)
              bus.position <= '0;
            else if (fwd)
              bus.position <= bus.position + 1'b1;
            else if (rev)
              bus.position <= bus.position - 1'b1;
            if (bad) bus.error <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
      if (bus.clear) begin
        bus.position  <= '0;
        bus.error     <= 1'b0;
        bus.direction <= 1'b0;
      end
    end
  end
endmodule
